// File: rtl/fx3_stream_writer.sv
// Drains the ADC show-ahead FIFO into the FX3 GPIF II slave-FIFO write port (thread 0),
// framing fixed-size packets and committing a short packet when capture stops.
module fx3_stream_writer #(
  parameter int DATA_WIDTH   = 16,
  parameter int PACKET_WORDS = 8192,
  parameter int SWITCH_GUARD = 4,
  parameter int COUNT_WIDTH  = 14
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  input  logic                   fifo_empty,
  output logic                   fifo_rd,
  input  logic                   th0_nReady,
  input  logic                   stop_request,
  output logic [DATA_WIDTH-1:0]  fx3_data,
  output logic                   fx3_nWrite,
  output logic                   fx3_nShort,
  output logic [COUNT_WIDTH-1:0] word_count,
  output logic [31:0]            packet_count,
  output logic                   error,
  output logic                   busy
);

  localparam int GUARD_WIDTH = (SWITCH_GUARD < 4) ? 3 : $clog2(SWITCH_GUARD + 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_WORD  = COUNT_WIDTH'(PACKET_WORDS - 1);
  localparam logic [GUARD_WIDTH-1:0] GUARD_LOAD = GUARD_WIDTH'(SWITCH_GUARD);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_READY,
    STREAM,
    SWITCH,
    SHORT,
    STOPPED
  } stateType;

  stateType                state;
  stateType                stateNext;
  logic [GUARD_WIDTH-1:0]  guardCount;
  logic [GUARD_WIDTH-1:0]  guardNext;
  logic [COUNT_WIDTH-1:0]  wordNext;
  logic [31:0]             packetNext;
  logic                    errorNext;
  logic [DATA_WIDTH-1:0]   dataNext;
  logic                    nWriteNext;
  logic                    nShortNext;

  // Reset is gated in so that no FIFO word is consumed and then thrown away by a reset edge.
  assign fifo_rd = (state == STREAM) && !reset && !fifo_empty && !th0_nReady && !stop_request;
  assign busy    = (state != IDLE);

  always_comb begin
    stateNext  = state;
    guardNext  = guardCount;
    wordNext   = word_count;
    packetNext = packet_count;
    errorNext  = error;
    dataNext   = fx3_data;
    nWriteNext = 1'b1;
    nShortNext = 1'b1;

    case (state)
      IDLE: begin
        if (!stop_request) stateNext = WAIT_READY;
      end

      WAIT_READY: begin
        guardNext = '0;
        if (stop_request) begin
          stateNext = (word_count != '0) ? SHORT : STOPPED;
        end else if (!th0_nReady) begin
          stateNext = STREAM;
        end
      end

      STREAM: begin
        if (stop_request) begin
          stateNext = (word_count != '0) ? SHORT : STOPPED;
        end else if (fifo_rd) begin
          dataNext   = fifo_data;
          nWriteNext = 1'b0;
          if (word_count == LAST_WORD) begin
            wordNext   = '0;
            packetNext = packet_count + 32'd1;
            guardNext  = GUARD_LOAD;
            stateNext  = SWITCH;
          end else begin
            wordNext = word_count + COUNT_WIDTH'(1);
          end
        end else if (th0_nReady && (word_count != '0)) begin
          errorNext = 1'b1;
        end
      end

      // Leave early: WAIT_READY plus the first STREAM cycle complete the guard window,
      // so the bus idles for exactly SWITCH_GUARD cycles between packets.
      SWITCH: begin
        if (guardCount <= GUARD_WIDTH'(2)) begin
          guardNext = '0;
          stateNext = stop_request ? STOPPED : WAIT_READY;
        end else begin
          guardNext = guardCount - GUARD_WIDTH'(1);
        end
      end

      SHORT: begin
        packetNext = packet_count + 32'd1;
        wordNext   = '0;
        stateNext  = STOPPED;
      end

      STOPPED: begin
        if (!stop_request) stateNext = IDLE;
      end

      default: stateNext = IDLE;
    endcase

    // The short strobe is registered, so it is raised on the edge that enters SHORT.
    if (stateNext == SHORT) nShortNext = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      guardCount   <= '0;
      word_count   <= '0;
      packet_count <= '0;
      error        <= 1'b0;
      fx3_data     <= '0;
      fx3_nWrite   <= 1'b1;
      fx3_nShort   <= 1'b1;
    end else begin
      state        <= stateNext;
      guardCount   <= guardNext;
      word_count   <= wordNext;
      packet_count <= packetNext;
      error        <= errorNext;
      fx3_data     <= dataNext;
      fx3_nWrite   <= nWriteNext;
      fx3_nShort   <= nShortNext;
    end
  end

endmodule
